// File: rtl/cache_line_fill_ctrl.sv
// cache_line_fill_ctrl: miss handler that writes back a dirty victim line,
// then refills the missing line with pipelined reads (optionally critical word first).
module cache_line_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int WORDS = 8,
    parameter int WORD_BYTES = 2,
    parameter bit CWF = 1'b0,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_address,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_write_ack,
    input  logic              mem_data_valid,
    output logic [IDX_W-1:0]  wb_index,
    output logic [IDX_W-1:0]  word_enable,
    output logic              wen_data,
    output logic              wen_tag,
    output logic              fsm_busy
);

    localparam int BYTE_SH = $clog2(WORD_BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS * WORD_BYTES - 1);
    localparam logic [IDX_W:0] CNT_END = (IDX_W + 1)'(WORDS);
    localparam logic [IDX_W:0] RSP_LAST = (IDX_W + 1)'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] vbase_q, vbase_d;
    logic [ADDR_W-1:0] lbase_q, lbase_d;
    logic [IDX_W-1:0] start_q, start_d;
    logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [IDX_W:0] req_q, req_d;
    logic [IDX_W:0] rsp_q, rsp_d;
    logic [IDX_W-1:0] miss_off;
    logic [IDX_W-1:0] req_word;
    logic [IDX_W-1:0] rsp_word;

    assign miss_off = IDX_W'(miss_address >> BYTE_SH);
    // IDX_W-bit sums wrap inside the line, so no carry reaches the tag bits
    assign req_word = start_q + req_q[IDX_W-1:0];
    assign rsp_word = start_q + rsp_q[IDX_W-1:0];
    assign fsm_busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vbase_q  <= '0;
            lbase_q  <= '0;
            start_q  <= '0;
            wb_idx_q <= '0;
            req_q    <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            vbase_q  <= vbase_d;
            lbase_q  <= lbase_d;
            start_q  <= start_d;
            wb_idx_q <= wb_idx_d;
            req_q    <= req_d;
            rsp_q    <= rsp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vbase_d     = vbase_q;
        lbase_d     = lbase_q;
        start_d     = start_q;
        wb_idx_d    = wb_idx_q;
        req_d       = req_q;
        rsp_d       = rsp_q;
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        wb_index    = '0;
        word_enable = '0;
        wen_data    = 1'b0;
        wen_tag     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    vbase_d  = victim_address & ~LINE_MASK;
                    lbase_d  = miss_address & ~LINE_MASK;
                    start_d  = CWF ? miss_off : '0;
                    wb_idx_d = '0;
                    req_d    = '0;
                    rsp_d    = '0;
                    state_d  = victim_dirty ? WB : FILL;
                end
            end
            WB: begin
                mem_write   = 1'b1;
                wb_index    = wb_idx_q;
                mem_address = vbase_q + (ADDR_W'(wb_idx_q) << BYTE_SH);
                if (mem_write_ack) begin
                    if (wb_idx_q == IDX_LAST) begin
                        state_d = FILL;
                    end else begin
                        wb_idx_d = wb_idx_q + 1'b1;
                    end
                end
            end
            FILL: begin
                // requests stream out without waiting for returned data
                if (req_q < CNT_END) begin
                    mem_read    = 1'b1;
                    mem_address = lbase_q + (ADDR_W'(req_word) << BYTE_SH);
                    req_d       = req_q + 1'b1;
                end
                if (mem_data_valid && (rsp_q < CNT_END)) begin
                    wen_data    = 1'b1;
                    word_enable = rsp_word;
                    rsp_d       = rsp_q + 1'b1;
                    if (rsp_q == RSP_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                wen_tag = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// tb_cache_line_fill_ctrl: three parameterisations driven together, each
// checked against transaction lists derived from line/offset arithmetic.
module tb_cache_line_fill_ctrl;

    logic clk;
    logic rst_n;
    logic miss_detected;
    logic victim_dirty;
    logic mem_write_ack;
    logic [15:0] ma16, va16;
    logic [31:0] ma32, va32;
    logic dv [3];
    logic rd [3];
    logic wr [3];
    logic wd [3];
    logic wt [3];
    logic bz [3];
    logic [15:0] a0, a1;
    logic [31:0] a2;
    logic [2:0] wbi0, wbi1, we0, we1;
    logic [1:0] wbi2, we2;

    int vectors, errors, cyc;
    int n_wr [3], n_rd [3], n_wd [3], n_wt [3], n_bz [3], bad [3];
    int first_wr [3], last_ack [3], first_rd [3], last_rd [3];
    int wt_cyc [3], first_bz [3], last_bz [3];
    longint unsigned wr_a [3][64];
    longint unsigned rd_a [3][64];
    int wr_i [3][64], wd_i [3][64], wd_c [3][64];
    bit sched [3][256];
    int last_t [3], rcount [3];
    int lat, jit;
    bit amode, spur, extra;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_line_fill_ctrl #(.ADDR_W(16), .WORDS(8), .WORD_BYTES(2), .CWF(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected),
        .miss_address(ma16), .victim_dirty(victim_dirty), .victim_address(va16),
        .mem_address(a0), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_write_ack(mem_write_ack), .mem_data_valid(dv[0]),
        .wb_index(wbi0), .word_enable(we0), .wen_data(wd[0]),
        .wen_tag(wt[0]), .fsm_busy(bz[0]));

    cache_line_fill_ctrl #(.ADDR_W(16), .WORDS(8), .WORD_BYTES(2), .CWF(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected),
        .miss_address(ma16), .victim_dirty(victim_dirty), .victim_address(va16),
        .mem_address(a1), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_write_ack(mem_write_ack), .mem_data_valid(dv[1]),
        .wb_index(wbi1), .word_enable(we1), .wen_data(wd[1]),
        .wen_tag(wt[1]), .fsm_busy(bz[1]));

    cache_line_fill_ctrl #(.ADDR_W(32), .WORDS(4), .WORD_BYTES(4), .CWF(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected),
        .miss_address(ma32), .victim_dirty(victim_dirty), .victim_address(va32),
        .mem_address(a2), .mem_read(rd[2]), .mem_write(wr[2]),
        .mem_write_ack(mem_write_ack), .mem_data_valid(dv[2]),
        .wb_index(wbi2), .word_enable(we2), .wen_data(wd[2]),
        .wen_tag(wt[2]), .fsm_busy(bz[2]));

    function automatic int nw(input int d);
        return (d == 2) ? 4 : 8;
    endfunction

    function automatic int nb(input int d);
        return (d == 2) ? 4 : 2;
    endfunction

    function automatic longint unsigned addr_of(input int d);
        return (d == 0) ? longint'(a0) : (d == 1) ? longint'(a1) : longint'(a2);
    endfunction

    function automatic int wbi_of(input int d);
        return (d == 0) ? int'(wbi0) : (d == 1) ? int'(wbi1) : int'(wbi2);
    endfunction

    function automatic int we_of(input int d);
        return (d == 0) ? int'(we0) : (d == 1) ? int'(we1) : int'(we2);
    endfunction

    function automatic bit any_out(input int d);
        return (addr_of(d) != 0) || (wbi_of(d) != 0) || (we_of(d) != 0) ||
               rd[d] || wr[d] || wd[d] || wt[d] || bz[d];
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rec(input int d);
        longint unsigned a;
        a = addr_of(d);
        if (rd[d] && wr[d]) bad[d]++;
        if (!bz[d] && any_out(d)) bad[d]++;
        if (wr[d]) begin
            if (first_wr[d] < 0) first_wr[d] = cyc;
            if (mem_write_ack) begin
                if (n_wr[d] < 64) begin
                    wr_a[d][n_wr[d]] = a;
                    wr_i[d][n_wr[d]] = wbi_of(d);
                end
                n_wr[d]++;
                last_ack[d] = cyc;
            end
        end
        if (rd[d]) begin
            if (first_rd[d] < 0) first_rd[d] = cyc;
            last_rd[d] = cyc;
            if (n_rd[d] < 64) rd_a[d][n_rd[d]] = a;
            n_rd[d]++;
        end
        if (wd[d]) begin
            if (n_wd[d] < 64) begin
                wd_i[d][n_wd[d]] = we_of(d);
                wd_c[d][n_wd[d]] = cyc;
            end
            n_wd[d]++;
        end
        if (wt[d]) begin
            n_wt[d]++;
            wt_cyc[d] = cyc;
        end
        if (bz[d]) begin
            if (first_bz[d] < 0) first_bz[d] = cyc;
            last_bz[d] = cyc;
            n_bz[d]++;
        end
    endtask

    // memory model: each read returns after lat..lat+jit cycles, in order
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        mem_write_ack = amode ? 1'(cyc % 2) : 1'($urandom);
        for (int d = 0; d < 3; d++) begin
            dv[d] = sched[d][cyc % 256] | (spur & 1'($urandom));
            sched[d][cyc % 256] = 1'b0;
            if (rd[d]) begin
                int t;
                t = cyc + lat + int'($urandom_range(0, jit));
                if (t <= last_t[d]) t = last_t[d] + 1;
                sched[d][t % 256] = 1'b1;
                last_t[d] = t;
                rcount[d]++;
                if (extra && rcount[d] == nw(d)) sched[d][(t + 1) % 256] = 1'b1;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rec(d);
    endtask

    task automatic clr();
        for (int d = 0; d < 3; d++) begin
            n_wr[d] = 0; n_rd[d] = 0; n_wd[d] = 0; n_wt[d] = 0;
            n_bz[d] = 0; bad[d] = 0;
            first_wr[d] = -1; last_ack[d] = -1; first_rd[d] = -1;
            last_rd[d] = -1; wt_cyc[d] = -1; first_bz[d] = -1; last_bz[d] = -1;
            last_t[d] = cyc; rcount[d] = 0;
        end
    endtask

    task automatic flush();
        for (int d = 0; d < 3; d++) begin
            dv[d] = 1'b0;
            for (int i = 0; i < 256; i++) sched[d][i] = 1'b0;
        end
    endtask

    task automatic check_dut(input int d, input int m, input longint unsigned miss,
                             input longint unsigned vict, input bit dirty);
        int w, b, st, r0;
        longint unsigned lm, base, vb;
        string p;
        w = nw(d);
        b = nb(d);
        lm = longint'(w * b - 1);
        base = miss & ~lm;
        vb = vict & ~lm;
        st = (d == 1) ? int'((miss / longint'(b)) % longint'(w)) : 0;
        r0 = dirty ? last_ack[d] + 1 : m + 1;
        p = $sformatf("d%0d@%0d", d, m);
        chk({p, ".n_wr"}, n_wr[d], dirty ? w : 0);
        if (dirty) begin
            chk({p, ".wb_start"}, first_wr[d], m + 1);
            for (int i = 0; i < w; i++) begin
                chk($sformatf("%s.wr_addr%0d", p, i), wr_a[d][i], vb + longint'(i * b));
                chk($sformatf("%s.wb_index%0d", p, i), wr_i[d][i], i);
            end
        end
        chk({p, ".fill_start"}, first_rd[d], r0);
        chk({p, ".n_rd"}, n_rd[d], w);
        chk({p, ".rd_span"}, last_rd[d] - first_rd[d], w - 1);
        for (int k = 0; k < w; k++) begin
            chk($sformatf("%s.rd_addr%0d", p, k), rd_a[d][k],
                base + longint'(((st + k) % w) * b));
        end
        chk({p, ".n_wen_data"}, n_wd[d], w);
        for (int k = 0; k < w; k++) begin
            chk($sformatf("%s.word_enable%0d", p, k), wd_i[d][k], (st + k) % w);
        end
        chk({p, ".n_wen_tag"}, n_wt[d], 1);
        chk({p, ".tag_cycle"}, wt_cyc[d], wd_c[d][w - 1] + 1);
        chk({p, ".busy_first"}, first_bz[d], m + 1);
        chk({p, ".busy_last"}, last_bz[d], wt_cyc[d]);
        chk({p, ".busy_len"}, n_bz[d], wt_cyc[d] - m);
        chk({p, ".protocol"}, bad[d], 0);
    endtask

    task automatic scenario(input logic [15:0] m16, input logic [15:0] v16,
                            input logic [31:0] m32, input logic [31:0] v32,
                            input bit dirty, input int pre);
        int m;
        bit done;
        spur = 1'b1;
        for (int i = 0; i < pre; i++) cycle();
        spur = 1'b0;
        clr();
        ma16 = m16; va16 = v16; ma32 = m32; va32 = v32;
        victim_dirty = dirty;
        miss_detected = 1'b1;
        m = cyc;
        cycle();
        miss_detected = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            ma16 = 16'($urandom); va16 = 16'($urandom);
            ma32 = $urandom; va32 = $urandom;
            victim_dirty = 1'($urandom);
            cycle();
            done = !(bz[0] || bz[1] || bz[2]);
        end
        chk("scenario.timeout", done, 1);
        for (int i = 0; i < 12; i++) cycle();
        flush();
        check_dut(0, m, longint'(m16), longint'(v16), dirty);
        check_dut(1, m, longint'(m16), longint'(v16), dirty);
        check_dut(2, m, longint'(m32), longint'(v32), dirty);
    endtask

    initial begin
        bit done;
        vectors = 0; errors = 0; cyc = 0;
        lat = 2; jit = 0; amode = 1'b0; spur = 1'b0; extra = 1'b0;
        rst_n = 1'b0;
        miss_detected = 1'b0; victim_dirty = 1'b0; mem_write_ack = 1'b0;
        ma16 = '0; va16 = '0; ma32 = '0; va32 = '0;
        flush();
        clr();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("reset.d%0d", d), any_out(d), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // clean miss straight out of reset, fixed 2-cycle latency
        scenario(16'h1236, 16'h0000, 32'h0000_1236, 32'h0, 1'b0, 0);

        lat = 3; jit = 2;
        scenario(16'h123A, 16'h0000, 32'hFFFF_FFF8, 32'h0, 1'b0, 2);

        lat = 1; jit = 1; amode = 1'b1;
        scenario(16'h5556, 16'h4402, 32'h0000_5556, 32'h8000_4402, 1'b1, 1);

        amode = 1'b0; extra = 1'b1; lat = 2; jit = 0;
        scenario(16'($urandom), 16'($urandom), $urandom, $urandom, 1'b0, 4);
        extra = 1'b0;

        // reset asserted while the 4th fill word is being returned
        clr();
        ma16 = 16'h1236; ma32 = 32'h1236; victim_dirty = 1'b0;
        miss_detected = 1'b1;
        cycle();
        miss_detected = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle();
            done = (n_wd[0] == 4) && wd[0];
        end
        chk("rst.reached_4th", done, 1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("rst.async.d%0d", d), any_out(d), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc++;
        flush();
        scenario(16'h123A, 16'h0000, 32'h0000_123A, 32'h0, 1'b0, 0);

        // miss held high through DONE: refill only after an idle cycle
        clr();
        ma16 = 16'h2000; ma32 = 32'h2000; victim_dirty = 1'b0;
        miss_detected = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle();
            done = (n_wt[0] != 0);
        end
        chk("hold.tag_seen", done, 1);
        cycle();
        chk("hold.idle_gap", bz[0], 0);
        cycle();
        chk("hold.refill", {bz[0], rd[0]}, 2'b11);
        miss_detected = 1'b0;
        for (int i = 0; i < 60; i++) cycle();
        flush();

        for (int n = 0; n < 8; n++) begin
            lat = int'($urandom_range(1, 4));
            jit = int'($urandom_range(0, 3));
            extra = 1'($urandom);
            scenario(16'($urandom), 16'($urandom), $urandom, $urandom,
                     1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
